apu_nest_seq: RTL and testbench

//  Multi-channel nested-loop address sequencer; autonomous successor to the single-step APU.

---
 rtl/apu_nest_seq.sv | 172 +++++++++++++++++
 tb/tb_apu_nest_seq.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/apu_nest_seq.sv
// Multi-channel nested-loop address sequencer.
// Walks a LOOP_CNT-deep loop nest and streams one address per channel on each accepted beat.
module apu_nest_seq #(
    parameter int BITS         = 8,
    parameter int LOG_LOOP_CNT = 1,
    parameter int LOG_APU_CNT  = 1,
    parameter int CNT_BITS     = 8,
    localparam int LOOP_CNT    = 1 << LOG_LOOP_CNT,
    localparam int APU_CNT     = 1 << LOG_APU_CNT,
    localparam int CFG_W       = (BITS > CNT_BITS) ? BITS : CNT_BITS
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         cfg_we,
    input  logic [1:0]                   cfg_field,
    input  logic [LOG_APU_CNT-1:0]       cfg_apu,
    input  logic [LOG_LOOP_CNT-1:0]      cfg_loop,
    input  logic [CFG_W-1:0]             cfg_data,
    input  logic                         start,
    input  logic                         abort,
    input  logic                         out_ready,
    output logic                         out_valid,
    output logic                         out_last,
    output logic [APU_CNT*BITS-1:0]      out_addr,
    output logic [LOOP_CNT*CNT_BITS-1:0] out_idx,
    output logic                         busy,
    output logic                         done
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [1:0] FLD_BASE   = 2'd0;
    localparam logic [1:0] FLD_STRIDE = 2'd1;
    localparam logic [1:0] FLD_BOUND  = 2'd2;

    logic [1:0]              state;
    logic [BITS-1:0]         base_r   [APU_CNT];
    logic [BITS-1:0]         stride_r [LOOP_CNT][APU_CNT];
    logic [CNT_BITS-1:0]     bound_r  [LOOP_CNT];
    logic [CNT_BITS-1:0]     idx_r    [LOOP_CNT];
    logic [BITS-1:0]         acc_r    [LOOP_CNT][APU_CNT];

    logic [CNT_BITS-1:0]     idx_max  [LOOP_CNT];
    logic [LOOP_CNT-1:0]     at_max;
    logic [LOG_LOOP_CNT-1:0] step_lvl;
    logic [CNT_BITS-1:0]     step_idx;
    logic [BITS-1:0]         step_acc [APU_CNT];
    logic                    run;
    logic                    last;
    logic                    xfer;
    logic                    cfg_ok;

    assign run    = (state == ST_RUN);
    assign xfer   = run && out_ready;
    assign cfg_ok = cfg_we && (state == ST_IDLE);

    // A programmed bound of 0 is treated as 1, so its terminal index is 0.
    always_comb begin
        for (int l = 0; l < LOOP_CNT; l++) begin
            idx_max[l] = (bound_r[l] == '0) ? '0 : bound_r[l] - CNT_BITS'(1);
            at_max[l]  = (idx_r[l] == idx_max[l]);
        end
    end

    assign last = run && (&at_max);

    // Carry search: the innermost loop that still has iterations left advances.
    always_comb begin
        logic found;
        found    = 1'b0;
        step_lvl = '0;
        for (int l = 0; l < LOOP_CNT; l++) begin
            if (!found && !at_max[l]) begin
                step_lvl = LOG_LOOP_CNT'(l);
                found    = 1'b1;
            end
        end
        step_idx = idx_r[step_lvl] + CNT_BITS'(1);
        for (int c = 0; c < APU_CNT; c++) begin
            step_acc[c] = acc_r[step_lvl][c] + stride_r[step_lvl][c];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int c = 0; c < APU_CNT; c++) begin
                base_r[c] <= '0;
            end
            for (int l = 0; l < LOOP_CNT; l++) begin
                bound_r[l] <= '0;
                for (int c = 0; c < APU_CNT; c++) begin
                    stride_r[l][c] <= '0;
                end
            end
        end else if (cfg_ok) begin
            case (cfg_field)
                FLD_BASE:   base_r[cfg_apu]             <= cfg_data[BITS-1:0];
                FLD_STRIDE: stride_r[cfg_loop][cfg_apu] <= cfg_data[BITS-1:0];
                FLD_BOUND:  bound_r[cfg_loop]           <= cfg_data[CNT_BITS-1:0];
                default:    ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
            for (int l = 0; l < LOOP_CNT; l++) begin
                idx_r[l] <= '0;
                for (int c = 0; c < APU_CNT; c++) begin
                    acc_r[l][c] <= '0;
                end
            end
        end else if (abort) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state <= ST_RUN;
                        for (int l = 0; l < LOOP_CNT; l++) begin
                            idx_r[l] <= '0;
                            for (int c = 0; c < APU_CNT; c++) begin
                                acc_r[l][c] <= base_r[c];
                            end
                        end
                    end
                end
                ST_RUN: begin
                    if (xfer && last) begin
                        state <= ST_DONE;
                    end else if (xfer) begin
                        // Levels below the stepping one restart from its new partial sum.
                        for (int l = 0; l < LOOP_CNT; l++) begin
                            if (LOG_LOOP_CNT'(l) == step_lvl) begin
                                idx_r[l] <= step_idx;
                            end else if (LOG_LOOP_CNT'(l) < step_lvl) begin
                                idx_r[l] <= '0;
                            end
                            if (LOG_LOOP_CNT'(l) <= step_lvl) begin
                                for (int c = 0; c < APU_CNT; c++) begin
                                    acc_r[l][c] <= step_acc[c];
                                end
                            end
                        end
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        out_addr = '0;
        out_idx  = '0;
        for (int c = 0; c < APU_CNT; c++) begin
            out_addr[c*BITS +: BITS] = acc_r[0][c];
        end
        for (int l = 0; l < LOOP_CNT; l++) begin
            out_idx[l*CNT_BITS +: CNT_BITS] = idx_r[l];
        end
    end

    assign out_valid = run;
    assign out_last  = last;
    assign busy      = (state != ST_IDLE);
    assign done      = (state == ST_DONE);

endmodule

// File: tb/tb_apu_nest_seq.sv
// Bench for apu_nest_seq: table of nest configurations with expected address lists,
// scoreboard of expected beats, plus hand sequences for abort, busy config writes and reset.
module tb_apu_nest_seq;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cfg_we = 1'b0;
    logic [1:0]  cfg_field = '0;
    logic [0:0]  cfg_apu = '0;
    logic [0:0]  cfg_loop = '0;
    logic [7:0]  cfg_data = '0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        out_ready = 1'b0;
    logic        out_valid;
    logic        out_last;
    logic [15:0] out_addr;
    logic [15:0] out_idx;
    logic        busy;
    logic        done;

    int n_tests = 0;
    int n_fail  = 0;

    apu_nest_seq dut (
        .clk(clk), .reset_n(reset_n), .cfg_we(cfg_we), .cfg_field(cfg_field),
        .cfg_apu(cfg_apu), .cfg_loop(cfg_loop), .cfg_data(cfg_data),
        .start(start), .abort(abort), .out_ready(out_ready),
        .out_valid(out_valid), .out_last(out_last), .out_addr(out_addr),
        .out_idx(out_idx), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] a0;
        logic [7:0] a1;
        logic [7:0] i0;
        logic [7:0] i1;
        logic       last;
    } beat_t;

    typedef struct packed {
        logic            do_cfg;
        logic            busy_cfg;
        logic            toggle;
        logic [7:0]      base0;
        logic [7:0]      base1;
        logic [7:0]      s00;   // loop0 ch0
        logic [7:0]      s01;   // loop0 ch1
        logic [7:0]      s10;   // loop1 ch0
        logic [7:0]      s11;   // loop1 ch1
        logic [7:0]      b0;
        logic [7:0]      b1;
        logic [3:0]      nbeats;
        logic [5:0][7:0] e0;
        logic [5:0][7:0] e1;
    } vec_t;

    beat_t sb[$];
    vec_t  vecs[6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cfg(input logic [1:0] f, input logic a, input logic l, input logic [7:0] d);
        @(negedge clk);
        cfg_we = 1'b1; cfg_field = f; cfg_apu = a; cfg_loop = l; cfg_data = d;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int         t;
        int         eb0;
        logic       r;
        logic       prev_stall;
        logic [31:0] prev;
        beat_t      e;
        if (v.do_cfg) begin
            cfg(2'd0, 1'b0, 1'b0, v.base0);
            cfg(2'd0, 1'b1, 1'b0, v.base1);
            cfg(2'd1, 1'b0, 1'b0, v.s00);
            cfg(2'd1, 1'b1, 1'b0, v.s01);
            cfg(2'd1, 1'b0, 1'b1, v.s10);
            cfg(2'd1, 1'b1, 1'b1, v.s11);
            cfg(2'd2, 1'b0, 1'b0, v.b0);
            cfg(2'd2, 1'b0, 1'b1, v.b1);
        end
        eb0 = (v.b0 == 0) ? 1 : int'(v.b0);
        for (int k = 0; k < int'(v.nbeats); k++) begin
            e.a0   = v.e0[k];
            e.a1   = v.e1[k];
            e.i0   = 8'(k % eb0);
            e.i1   = 8'(k / eb0);
            e.last = (k == int'(v.nbeats) - 1);
            sb.push_back(e);
        end
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        t = 0;
        prev_stall = 1'b0;
        prev = '0;
        while (sb.size() > 0 && t < 200) begin
            r = v.toggle ? (t % 3 == 0) : 1'b1;
            out_ready = r;
            if (v.busy_cfg) begin
                cfg_we = (t == 0); cfg_field = 2'd0; cfg_apu = 1'b0; cfg_data = 8'd99;
            end
            if (!out_valid) begin
                check({tag, " valid"}, 64'(out_valid), 64'd1);
                sb.delete();
            end else begin
                if (prev_stall) check({tag, " hold"}, 64'({out_addr, out_idx}), 64'(prev));
                if (r) begin
                    e = sb.pop_front();
                    check({tag, " addr"}, 64'(out_addr), 64'({e.a1, e.a0}));
                    check({tag, " idx"},  64'(out_idx),  64'({e.i1, e.i0}));
                    check({tag, " last"}, 64'(out_last), 64'(e.last));
                end
                prev_stall = !r;
                prev = {out_addr, out_idx};
            end
            t++;
            @(negedge clk);
        end
        cfg_we = 1'b0;
        out_ready = 1'b0;
        if (sb.size() != 0) begin
            check({tag, " timeout"}, 64'(sb.size()), 64'd0);
            sb.delete();
        end
        check({tag, " done"},      64'(done),      64'd1);
        check({tag, " done_valid"}, 64'(out_valid), 64'd0);
        @(negedge clk);
        check({tag, " done_pulse"}, 64'(done), 64'd0);
        check({tag, " idle"},       64'(busy), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{do_cfg:1, busy_cfg:0, toggle:0, base0:0, base1:10, s00:1, s01:3, s10:2, s11:4,
                    b0:2, b1:3, nbeats:6,
                    e0:{8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0},
                    e1:{8'd21, 8'd18, 8'd17, 8'd14, 8'd13, 8'd10}};
        vecs[1] = vecs[0];
        vecs[1].do_cfg = 1'b0;
        vecs[1].toggle = 1'b1;
        vecs[2] = '{do_cfg:1, busy_cfg:0, toggle:0, base0:250, base1:7, s00:3, s01:100, s10:0, s11:0,
                    b0:4, b1:1, nbeats:4,
                    e0:{8'd0, 8'd0, 8'd3, 8'd0, 8'd253, 8'd250},
                    e1:{8'd0, 8'd0, 8'd51, 8'd207, 8'd107, 8'd7}};
        vecs[3] = '{do_cfg:1, busy_cfg:0, toggle:0, base0:5, base1:9, s00:1, s01:1, s10:1, s11:1,
                    b0:0, b1:0, nbeats:1,
                    e0:{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd5},
                    e1:{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd9}};
        vecs[4] = vecs[0];
        vecs[4].do_cfg = 1'b0;
        vecs[4].busy_cfg = 1'b1;
        vecs[5] = '{do_cfg:0, busy_cfg:0, toggle:0, base0:0, base1:0, s00:0, s01:0, s10:0, s11:0,
                    b0:0, b1:0, nbeats:1, e0:'0, e1:'0};

        repeat (2) @(negedge clk);
        check("rst valid", 64'(out_valid), 64'd0);
        check("rst busy",  64'(busy),      64'd0);
        check("rst addr",  64'(out_addr),  64'd0);
        check("rst idx",   64'(out_idx),   64'd0);
        check("rst done",  64'(done),      64'd0);
        reset_n = 1'b1;

        for (int i = 0; i < 4; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Reload the basic nest, then abort while the third beat is presented.
        run_vec(vecs[0], "reload");
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("abort beat3", 64'(out_addr), 64'({8'd14, 8'd2}));
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0; out_ready = 1'b0;
        check("abort valid", 64'(out_valid), 64'd0);
        check("abort busy",  64'(busy),      64'd0);
        check("abort done",  64'(done),      64'd0);
        @(negedge clk);
        check("abort nodone", 64'(done), 64'd0);

        run_vec(vecs[4], "busycfg");
        run_vec(vecs[0].do_cfg ? vecs[1] : vecs[1], "replay");

        // Asynchronous reset in the middle of a run.
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("arst valid", 64'(out_valid), 64'd0);
        check("arst busy",  64'(busy),      64'd0);
        check("arst addr",  64'(out_addr),  64'd0);
        check("arst idx",   64'(out_idx),   64'd0);
        check("arst last",  64'(out_last),  64'd0);
        @(negedge clk);
        reset_n = 1'b1; out_ready = 1'b0;
        run_vec(vecs[5], "postrst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
